// File: rtl/cavlc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cavlc_pkg
// Purpose : Shared types and constants for the CAVLC scan controller slice.
//           Holds the controller state encoding, coefficient width, block
//           sizes and a helper that recognises trailing-one candidates.
// Ports   : none (package)
// Config  : CAVLC_CHROMA_DC_EN (used by cavlc_scan_ctrl) enables 4-entry
//           chroma-DC scans.
// Rev     : 1.0  initial release
// ============================================================================
package cavlc_pkg;

  localparam int COEFF_W = 8;
  localparam int BLK_N   = 16;
  localparam int CDC_N   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CLR  = 2'd1,
    ST_SCAN = 2'd2,
    ST_DONE = 2'd3
  } scan_state_t;

  // True for +1 / -1 in two's complement, i.e. a trailing-one candidate.
  function automatic logic is_t1(input logic [COEFF_W-1:0] v);
    return (v == {{(COEFF_W-1){1'b0}}, 1'b1}) || (v == {COEFF_W{1'b1}});
  endfunction

endpackage
`default_nettype wire

// File: rtl/cavlc_scan_stats.sv
`default_nettype none
// ============================================================================
// Module  : cavlc_scan_stats
// Purpose : Per-block statistics gathered while the controller scans a block
//           from its highest index down: trailing-ones count and stop flag,
//           nonzero coefficient count and zeros below the last nonzero.
// Ports   : clk, rst        clock, synchronous active-high reset
//           clr             synchronous clear of all counters
//           valid           coeff carries a scanned coefficient this cycle
//           coeff           scanned coefficient
//           started         a nonzero has been seen at or above this index
//           t1_cnt, t1_stop trailing-ones count / counting ended (sticky)
//           total_coeff     nonzero count, saturating at 16
//           total_zeros     zeros below the highest nonzero index
// Rev     : 1.0  initial release
// ============================================================================
module cavlc_scan_stats
  import cavlc_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               valid,
  input  logic [COEFF_W-1:0] coeff,
  input  logic               started,
  output logic [1:0]         t1_cnt,
  output logic               t1_stop,
  output logic [4:0]         total_coeff,
  output logic [3:0]         total_zeros
);

  logic nonzero;
  assign nonzero = (coeff != '0);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      t1_cnt      <= 2'd0;
      t1_stop     <= 1'b0;
      total_coeff <= 5'd0;
      total_zeros <= 4'd0;
    end else if (valid) begin
      if (nonzero) begin
        if (total_coeff != 5'(BLK_N)) begin
          total_coeff <= total_coeff + 5'd1;
        end
        if (!t1_stop) begin
          if (is_t1(coeff)) begin
            t1_cnt <= t1_cnt + 2'd1;
            // The third trailing one closes the run.
            if (t1_cnt == 2'd2) begin
              t1_stop <= 1'b1;
            end
          end else begin
            t1_stop <= 1'b1;
          end
        end
      end else if (started && (total_zeros != 4'd15)) begin
        // A zero only counts once a higher-index nonzero has been seen.
        total_zeros <= total_zeros + 4'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cavlc_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : cavlc_scan_ctrl
// Purpose : Accepts a 4x4 block of zigzag-ordered coefficients, clears the
//           level-list datapath, scans coefficients from the highest index
//           down to 0 (one per cycle) and presents the CAVLC block summary
//           through a valid/ready handshake.
// Ports   : clk, rst                  clock, synchronous active-high reset
//           h264_reset                synchronous frame abort
//           blk_valid/blk_ready       block input handshake
//           blk_coeff[0:15]           signed coefficients, blk_is_cdc flag
//           cnt_rst_o                 one-cycle datapath clear
//           start_cnt_o, coeff_o      scan stream
//           t1_cnt_o, t1_stop_o       live trailing-ones state
//           sum_valid/sum_ready       summary handshake
//           total_coeff_o, total_zeros_o, trailing_ones_o  summary values
// Config  : CAVLC_CHROMA_DC_EN -- when defined, blk_is_cdc=1 selects a
//           4-entry scan (indices 3..0); otherwise blk_is_cdc is ignored.
// Rev     : 1.0  initial release
// ============================================================================
module cavlc_scan_ctrl
  import cavlc_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      h264_reset,
  input  logic                      blk_valid,
  output logic                      blk_ready,
  input  logic signed [COEFF_W-1:0] blk_coeff [0:BLK_N-1],
  input  logic                      blk_is_cdc,
  output logic                      cnt_rst_o,
  output logic                      start_cnt_o,
  output logic [COEFF_W-1:0]        coeff_o,
  output logic [1:0]                t1_cnt_o,
  output logic                      t1_stop_o,
  output logic                      sum_valid,
  input  logic                      sum_ready,
  output logic [4:0]                total_coeff_o,
  output logic [3:0]                total_zeros_o,
  output logic [1:0]                trailing_ones_o
);

  scan_state_t               state;
  logic [COEFF_W-1:0]        coeff_q [0:BLK_N-1];
  logic [3:0]                idx;
  logic                      seen_nz;
  logic [3:0]                first_idx;
  logic                      abort;
  logic                      accept;
  logic                      scanning;
  logic [COEFF_W-1:0]        cur;
  logic                      cur_nz;

  // Either reset wins over any handshake in the same cycle.
  assign abort  = rst | h264_reset;
  assign accept = blk_valid & blk_ready & ~abort;

`ifdef CAVLC_CHROMA_DC_EN
  assign first_idx = blk_is_cdc ? 4'(CDC_N - 1) : 4'(BLK_N - 1);
`else
  logic unused_cdc;
  assign unused_cdc = blk_is_cdc;
  assign first_idx  = 4'(BLK_N - 1);
`endif

  assign scanning = (state == ST_SCAN);
  assign cur      = coeff_q[idx];
  assign cur_nz   = (cur != '0);

  always_ff @(posedge clk) begin
    if (abort) begin
      state   <= ST_IDLE;
      idx     <= 4'd0;
      seen_nz <= 1'b0;
      for (int i = 0; i < BLK_N; i++) begin
        coeff_q[i] <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            for (int i = 0; i < BLK_N; i++) begin
              coeff_q[i] <= blk_coeff[i];
            end
            idx   <= first_idx;
            state <= ST_CLR;
          end
        end
        ST_CLR: begin
          seen_nz <= 1'b0;
          state   <= ST_SCAN;
        end
        ST_SCAN: begin
          if (cur_nz) begin
            seen_nz <= 1'b1;
          end
          if (idx == 4'd0) begin
            state <= ST_DONE;
          end else begin
            idx <= idx - 4'd1;
          end
        end
        ST_DONE: begin
          if (sum_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign blk_ready   = (state == ST_IDLE);
  assign cnt_rst_o   = (state == ST_CLR);
  assign sum_valid   = (state == ST_DONE);
  assign coeff_o     = scanning ? cur : '0;
  // Leading zeros are suppressed; the first nonzero opens the window.
  assign start_cnt_o = scanning & (seen_nz | cur_nz);

  cavlc_scan_stats u_stats (
    .clk         (clk),
    .rst         (rst),
    .clr         (h264_reset | cnt_rst_o),
    .valid       (scanning),
    .coeff       (cur),
    .started     (start_cnt_o),
    .t1_cnt      (t1_cnt_o),
    .t1_stop     (t1_stop_o),
    .total_coeff (total_coeff_o),
    .total_zeros (total_zeros_o)
  );

  assign trailing_ones_o = t1_cnt_o;

endmodule
`default_nettype wire
